// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM states and
// the supported operand-width range.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 64;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder; the one arithmetic stage reused every cycle by
// the serial adder.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract: one full-adder stage, LSB first, WIDTH cycles per
// operation; the result registers hold the previous answer until the next one.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // One extra counter bit so a power-of-two WIDTH never wraps to zero.
  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("serial_adder: WIDTH out of range");
  end

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
  logic             ovf_q;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] res_d;
  logic             last_bit;

  full_adder u_fa (
    .a_i  (a_q[0]),
    .b_i  (b_q[0]),
    .ci_i (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  assign res_d    = {fa_s, res_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            // Subtraction is A + ~B + 1, so invert B and force the carry-in.
            a_q     <= a;
            b_q     <= b ^ {WIDTH{sub}};
            carry_q <= sub ? 1'b1 : cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          res_q   <= res_d;
          carry_q <= fa_co;
          cnt_q   <= cnt_q + 1'b1;
          if (last_bit) begin
            // On the MSB step carry_q still holds the carry into the MSB.
            sum_q   <= res_d;
            cout_q  <= fa_co;
            ovf_q   <= carry_q ^ fa_co;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH 8, 2 and 16 with an
// arithmetic reference model feeding an expected-result queue.
module tb_serial_adder;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       o;
  } exp8_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic        start8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;

  logic        start2 = 1'b0, cin2 = 1'b0, sub2 = 1'b0;
  logic [1:0]  a2 = '0, b2 = '0;
  logic        busy2, done2, cout2, ovf2;
  logic [1:0]  sum2;

  logic        start16 = 1'b0, cin16 = 1'b0, sub16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;

  int errors = 0;
  int checks = 0;
  exp8_t sb[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2), .sub(sub2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16), .sub(sub16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  // Reference: plain wide addition, overflow from operand/result sign bits.
  function automatic exp8_t model8(input logic [7:0] a, input logic [7:0] b,
                                   input logic cin, input logic sub);
    logic [8:0] full;
    logic [7:0] bb;
    exp8_t e;
    bb     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + {8'd0, (sub ? 1'b1 : cin)};
    e.s    = full[7:0];
    e.c    = full[8];
    e.o    = (a[7] == bb[7]) && (e.s[7] != a[7]);
    return e;
  endfunction

  // Drives one 8-bit operation, scrambles operands after acceptance and
  // reports what the DUT produced, how long it took and whether sum moved early.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input logic sub, output bit got, output int lat, output int bcnt,
                      output bit stable, output logic [7:0] s, output logic c, output logic o);
    logic [7:0] prev;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = cin; sub8 = sub; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = ~a; b8 = ~b; cin8 = ~cin; sub8 = ~sub;
    prev = sum8; got = 1'b0; lat = 0; stable = 1'b1;
    bcnt = busy8 ? 1 : 0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done8) got = 1'b1;
      else begin
        if (busy8) bcnt++;
        if (sum8 !== prev) stable = 1'b0;
      end
    end
    s = sum8; c = cout8; o = ovf8;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'd0) begin
      errors++;
      $display("FAIL reset_async8 got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
               busy8, done8, sum8, cout8, ovf8);
    end
    checks++;
    if ({busy16, done16, sum16, cout16, ovf16, busy2, done2, sum2} !== 24'd0) begin
      errors++;
      $display("FAIL reset_async_w got sum16=%h sum2=%h busy16=%b want 0", sum16, sum2, busy16);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    $display("reset released");
  endtask

  // Runs one op through the queue and checks result, latency, busy and pulse width.
  task automatic test_op(input string nm, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic sub);
    bit got, stable;
    int lat, bcnt;
    logic [7:0] s;
    logic c, o;
    exp8_t e;
    sb.push_back(model8(a, b, cin, sub));
    run8(a, b, cin, sub, got, lat, bcnt, stable, s, c, o);
    e = sb.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout no done within 40 cycles", nm);
      return;
    end
    $display("op %s a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b lat=%0d",
             nm, a, b, cin, sub, s, c, o, lat);
    checks++;
    if ({s, c, o} !== {e.s, e.c, e.o}) begin
      errors++;
      $display("FAIL %s_result got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
               nm, s, c, o, e.s, e.c, e.o);
    end
    checks++;
    if (lat != 8 || bcnt != 8) begin
      errors++;
      $display("FAIL %s_timing got lat=%0d busy_cycles=%0d want 8/8", nm, lat, bcnt);
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL %s_stable sum changed during RUN want held", nm);
    end
    @(posedge clk); #1;
    checks++;
    if (done8 !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse got done=%b one cycle later want 0", nm, done8);
    end
  endtask

  task automatic test_vectors();
    exp8_t e;
    // Hand-derived expectations cross-check the reference model itself.
    e = model8(8'h5A, 8'h3C, 1'b0, 1'b0);
    checks++;
    if ({e.s, e.c, e.o} !== {8'h96, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL model_5A3C got %h/%b/%b want 96/0/1", e.s, e.c, e.o);
    end
    test_op("add_5A_3C", 8'h5A, 8'h3C, 1'b0, 1'b0);
    test_op("add_FF_01", 8'hFF, 8'h01, 1'b0, 1'b0);
    test_op("add_FF_00_cin", 8'hFF, 8'h00, 1'b1, 1'b0);
    test_op("sub_10_20", 8'h10, 8'h20, 1'b1, 1'b1);
    test_op("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      test_op($sformatf("rand%0d", i), 8'($urandom), 8'($urandom),
              1'($urandom), 1'($urandom));
  endtask

  task automatic test_back_to_back();
    int ndone = 0;
    int lat2 = 0;
    exp8_t e;
    sb.push_back(model8(8'h12, 8'h34, 1'b0, 1'b0));
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
      @(posedge clk); #1;
      if (done8) ndone++;
    end
    e = sb.pop_front();
    checks++;
    if (ndone != 1 || !done8 || {sum8, cout8, ovf8} !== {e.s, e.c, e.o}) begin
      errors++;
      $display("FAIL hold_first got dones=%0d done=%b sum=%h cout=%b ovf=%b want 1/1 %h/%b/%b",
               ndone, done8, sum8, cout8, ovf8, e.s, e.c, e.o);
    end
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; sub8 = 1'b0;
    sb.push_back(model8(8'h01, 8'h02, 1'b0, 1'b0));
    @(posedge clk); #1;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL hold_done_state got busy=%b done=%b want 0/0", busy8, done8);
    end
    @(posedge clk); #1;
    checks++;
    if (busy8 !== 1'b1) begin
      errors++;
      $display("FAIL hold_reaccept got busy=%b want 1", busy8);
    end
    start8 = 1'b0;
    while (!done8 && lat2 < 40) begin
      @(posedge clk); #1;
      lat2++;
    end
    e = sb.pop_front();
    checks++;
    if (!done8 || lat2 != 8 || {sum8, cout8, ovf8} !== {e.s, e.c, e.o}) begin
      errors++;
      $display("FAIL hold_second got done=%b lat=%0d sum=%h want 1/8 sum=%h", done8, lat2, sum8, e.s);
    end
    $display("back_to_back second result sum=%h lat=%0d", sum8, lat2);
  endtask

  task automatic test_reset_mid_run();
    int ndone = 0;
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'd0) begin
      errors++;
      $display("FAIL midrun_async got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
               busy8, done8, sum8, cout8, ovf8);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done8 || busy8) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL midrun_no_done got %0d active cycles after abort want 0", ndone);
    end
    test_op("post_reset_3_4", 8'h03, 8'h04, 1'b0, 1'b0);
  endtask

  task automatic test_widths();
    int lat = 0;
    @(negedge clk);
    a2 = 2'b01; b2 = 2'b01; cin2 = 1'b0; sub2 = 1'b0; start2 = 1'b1;
    a16 = 16'h7FFF; b16 = 16'h0001; cin16 = 1'b0; sub16 = 1'b0; start16 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0; start16 = 1'b0; a2 = 2'b11; a16 = 16'h1234;
    while (!done2 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (!done2 || lat != 2 || {sum2, cout2, ovf2} !== {2'b10, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL w2_add got done=%b lat=%0d sum=%b cout=%b ovf=%b want 1/2 10/0/1",
               done2, lat, sum2, cout2, ovf2);
    end
    while (!done16 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (!done16 || lat != 16 || {sum16, cout16, ovf16} !== {16'h8000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL w16_add got done=%b lat=%0d sum=%h cout=%b ovf=%b want 1/16 8000/0/1",
               done16, lat, sum16, cout16, ovf16);
    end
    $display("widths w2 sum=%b w16 sum=%h", sum2, sum16);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    test_widths();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A, captured on the accepted start.
REQ-006 b  input  WIDTH  operand B, captured on the accepted start.
REQ-007 cin  input  1  carry-in for add mode, captured on the accepted start.
REQ-008 sub  input  1  mode, captured on the accepted start: 0 = A+B+cin, 1 = A-B (cin ignored).
REQ-009 busy  output  1  high while the state is RUN.
REQ-010 done  output  1  one-cycle pulse when the result becomes valid.
REQ-011 sum  output  WIDTH  result; holds its value until the next completion.
REQ-012 cout  output  1  carry out of the MSB; in sub mode 1 = no borrow.
REQ-013 ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 IDLE with start=1 at an edge SHALL capture a, b XOR {WIDTH{sub}}, carry=(sub ? 1 : cin), set the bit counter to 0, and go to RUN.
REQ-016 IDLE with start=0 SHALL remain in IDLE.
REQ-017 Each RUN edge SHALL process one bit, LSB first, through one 1-bit full-adder stage: the sum bit shifts into the result register, carry-out updates the carry register, and the counter increments.
REQ-018 The carry into the MSB SHALL be saved during the final RUN edge for ovf computation.
REQ-019 At the WIDTH-th RUN edge the block SHALL update sum, cout and ovf together, go to DONE, and assert done.
REQ-020 Latency: done SHALL be high in exactly the cycle after the WIDTH-th edge following the edge that accepted start.
REQ-021 DONE SHALL go to IDLE unconditionally on the next edge; done is high for exactly one cycle.
REQ-022 start SHALL be ignored in RUN and DONE: no restart and no operand recapture.
REQ-023 The earliest next acceptance SHALL be the edge after DONE, i.e. back-to-back throughput of one result per WIDTH+2 cycles.
REQ-024 Operand inputs SHALL be don't-care outside the accepting edge; later changes to them SHALL NOT affect the result.
REQ-025 sum, cout and ovf SHALL NOT change during RUN; the previous result stays visible.
REQ-026 The counter SHALL be $clog2(WIDTH)+1 bits wide so that WIDTH=2^k terminates without wrap-around ambiguity.
REQ-027 Arithmetic SHALL be modulo 2^WIDTH; carry out of the MSB is reported only on cout.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for a clock edge, force IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, and clear the counter, carry and operand registers.
REQ-029 Reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-030 After reset deassertion, the first start SHALL be accepted at the first rising edge with start=1.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE/RUN/DONE) and the WIDTH legality bounds.
REQ-032 The 1-bit add stage SHALL be one instance of the team's existing full_adder sub-module; no other sub-modules.
REQ-033 All registers SHALL be in a single always block with asynchronous reset; outputs are registered.

Verification
REQ-034 WIDTH=8, a=0x5A b=0x3C cin=0 sub=0 -> sum=0x96 cout=0 ovf=1, done 8 edges after the start edge, busy high for 8 cycles.
REQ-035 a=0xFF b=0x01 cin=0 sub=0, then a=0xFF b=0x00 cin=1 -> both give sum=0x00 cout=1 ovf=0.
REQ-036 sub=1, a=0x10 b=0x20 -> sum=0xF0 cout=0 ovf=0; a=0x80 b=0x01 -> sum=0x7F cout=1 ovf=1.
REQ-037 start held high and a/b toggled during RUN -> single done pulse, result from the first capture only, next start accepted only after DONE.
REQ-038 rst_n pulsed low at RUN bit 4 -> all outputs 0 asynchronously, no done pulse; a fresh op 3+4 -> sum=0x07.
REQ-039 Repeat REQ-034 at WIDTH=2 and WIDTH=16 (0x7FFF+0x0001 -> sum=0x8000 ovf=1) -> done at the WIDTH-th edge.
